// File: rtl/risc_pkg.sv
// ---------------------------------------------------------------------------
// risc_pkg
//   Definitions shared by the multi-cycle control path.
//   - stage_e        : sequencer state encoding (FETCH=0 .. HALT=6); the same
//                      encoding is presented on the sequencer's stage port.
//   - INT_VEC_DEFAULT: default PC loaded on interrupt entry.
//   - WCNT_W         : width of the MEM-stage wait counter.
// ---------------------------------------------------------------------------
package risc_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        INTE   = 3'd5,
        HALT   = 3'd6
    } stage_e;

    localparam logic [31:0] INT_VEC_DEFAULT = 32'h0000_0040;

    localparam int WCNT_W = 4;

endpackage : risc_pkg

// File: rtl/wait_counter.sv
// ---------------------------------------------------------------------------
// wait_counter
//   Minimum-residency counter for the MEM stage. Loaded once on MEM entry,
//   then counts down to zero and holds there.
//
//   clk      in   clock
//   rst      in   asynchronous active-low reset (count cleared to 0)
//   load     in   load load_val this cycle (has priority over dec)
//   load_val in   WCNT_W-bit value to load
//   dec      in   decrement while nonzero
//   zero     out  count == 0
// ---------------------------------------------------------------------------
module wait_counter
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WCNT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [WCNT_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule : wait_counter

// File: rtl/cycle_sequencer.sv
// ---------------------------------------------------------------------------
// cycle_sequencer
//   Multi-cycle control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH,
//   with HALT and (optionally) interrupt entry through INTE.
//
//   Build option: define CYCLE_SEQ_INT_EN to enable interrupt handling
//   (INTE state, interrupt mask, INT input). Without it INT is ignored,
//   pcSel/epcSave/intAck are tied low and HALT is left only through reset.
//
//   Parameters
//     MEM_WAIT     minimum cycles spent in MEM (1..15)
//     INT_VEC      PC value used when pcSel=1 (presented on intVec)
//     RET_CNT_INIT reset value of retCnt (0 for normal use; a nonzero preload
//                  lets the counter wrap be exercised quickly)
//
//   Ports
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-low reset
//     INT       in   level interrupt request
//     isHalt    in   decoded HALT, valid from DECODE onward
//     isMem     in   decoded load/store, valid from DECODE onward
//     isWr      in   decoded register write, valid from DECODE onward
//     memReady  in   data memory completion
//     stage     out  current state (risc_pkg::stage_e encoding)
//     irEn .. pcEn   out  datapath stage strobes
//     pcSel     out  0 = sequential next PC, 1 = INT_VEC
//     epcSave   out  capture current PC into EPC
//     intAck    out  interrupt acknowledge pulse
//     halted    out  core halted
//     retCnt    out  retired instruction count (wraps)
//     intVec    out  interrupt vector constant for the PC mux
// ---------------------------------------------------------------------------
module cycle_sequencer
    import risc_pkg::*;
#(
    parameter int unsigned MEM_WAIT     = 1,
    parameter logic [31:0] INT_VEC      = INT_VEC_DEFAULT,
    parameter logic [15:0] RET_CNT_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        isHalt,
    input  logic        isMem,
    input  logic        isWr,
    input  logic        memReady,
    output logic [2:0]  stage,
    output logic        irEn,
    output logic        regEn,
    output logic        aluEn,
    output logic        memEn,
    output logic        wbEn,
    output logic        pcEn,
    output logic        pcSel,
    output logic        epcSave,
    output logic        intAck,
    output logic        halted,
    output logic [15:0] retCnt,
    output logic [31:0] intVec
);

    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(MEM_WAIT - 1);

    stage_e state, state_nxt;

    logic ir_en, reg_en, alu_en, mem_en, wb_en, pc_en, halt_st;
    logic wc_load, wc_dec, wc_zero;
    logic int_take;
    logic [15:0] ret_cnt;

    // -----------------------------------------------------------------------
    // Interrupt qualification. The mask is set on entry and only released
    // once INT is seen low in FETCH, so a held level request cannot re-enter.
    // -----------------------------------------------------------------------
`ifdef CYCLE_SEQ_INT_EN
    logic int_mask;
    logic pc_sel, epc_save, int_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_mask <= 1'b0;
        end else if (state == INTE) begin
            int_mask <= 1'b1;
        end else if (state == FETCH && !INT) begin
            int_mask <= 1'b0;
        end
    end

    assign int_take = INT & ~int_mask;
`else
    logic unused_int;
    assign unused_int = INT;
    assign int_take   = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // MEM residency counter: loaded on the EXEC->MEM edge.
    // -----------------------------------------------------------------------
    assign wc_load = (state == EXEC) && isMem;
    assign wc_dec  = (state == MEM);

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (wc_load),
        .load_val (WAIT_LOAD),
        .dec      (wc_dec),
        .zero     (wc_zero)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and stage strobes (Moore, except wbEn which follows isWr)
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_nxt = state;
        ir_en     = 1'b0;
        reg_en    = 1'b0;
        alu_en    = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        halt_st   = 1'b0;
`ifdef CYCLE_SEQ_INT_EN
        pc_sel    = 1'b0;
        epc_save  = 1'b0;
        int_ack   = 1'b0;
`endif
        case (state)
            FETCH: begin
                ir_en     = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                reg_en    = 1'b1;
                state_nxt = isHalt ? HALT : EXEC;
            end
            EXEC: begin
                alu_en    = 1'b1;
                state_nxt = isMem ? MEM : WB;
            end
            MEM: begin
                mem_en = 1'b1;
                // memReady only counts once the minimum wait has elapsed.
                if (wc_zero && memReady) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                wb_en     = isWr;
                pc_en     = 1'b1;
                state_nxt = int_take ? INTE : FETCH;
            end
`ifdef CYCLE_SEQ_INT_EN
            INTE: begin
                pc_en     = 1'b1;
                pc_sel    = 1'b1;
                epc_save  = 1'b1;
                int_ack   = 1'b1;
                state_nxt = FETCH;
            end
`endif
            HALT: begin
                halt_st = 1'b1;
                if (int_take) begin
                    state_nxt = INTE;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Retired instruction counter: one increment per WB cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_cnt <= RET_CNT_INIT;
        end else if (state == WB) begin
            ret_cnt <= ret_cnt + 16'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. The reset state is FETCH, whose decode would raise irEn, so
    // every strobe is qualified by rst to be low for as long as reset is held.
    // -----------------------------------------------------------------------
    assign stage   = state;
    assign irEn    = ir_en   & rst;
    assign regEn   = reg_en  & rst;
    assign aluEn   = alu_en  & rst;
    assign memEn   = mem_en  & rst;
    assign wbEn    = wb_en   & rst;
    assign pcEn    = pc_en   & rst;
    assign halted  = halt_st & rst;
`ifdef CYCLE_SEQ_INT_EN
    assign pcSel   = pc_sel   & rst;
    assign epcSave = epc_save & rst;
    assign intAck  = int_ack  & rst;
`else
    assign pcSel   = 1'b0;
    assign epcSave = 1'b0;
    assign intAck  = 1'b0;
`endif
    assign retCnt  = ret_cnt;
    assign intVec  = INT_VEC;

endmodule : cycle_sequencer

// File: tb/tb_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cycle_sequencer
//   Directed + randomized bench for cycle_sequencer (MEM_WAIT=3). Each
//   instruction's expected stage sequence is built as a list from the
//   instruction's attributes, then compared cycle by cycle. A second instance
//   preloaded with retCnt=16'hFFFF tracks the counter wrap.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cycle_sequencer;

    localparam int MEM_WAIT = 3;
`ifdef CYCLE_SEQ_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
        S_WB    = 3'd4, S_INTE   = 3'd5, S_HALT = 3'd6
    } st_t;

    logic        clk, rst, INT, isHalt, isMem, isWr, memReady;
    logic [2:0]  stage;
    logic        irEn, regEn, aluEn, memEn, wbEn, pcEn, pcSel, epcSave, intAck, halted;
    logic [15:0] retCnt;
    logic [31:0] intVec;

    logic [2:0]  w_stage;
    logic        w_irEn, w_regEn, w_aluEn, w_memEn, w_wbEn, w_pcEn;
    logic        w_pcSel, w_epcSave, w_intAck, w_halted;
    logic [15:0] w_retCnt;
    logic [31:0] w_intVec;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] ret_model;
    bit          mask_model;

    cycle_sequencer #(.MEM_WAIT(MEM_WAIT)) dut (
        .clk(clk), .rst(rst), .INT(INT), .isHalt(isHalt), .isMem(isMem),
        .isWr(isWr), .memReady(memReady), .stage(stage), .irEn(irEn),
        .regEn(regEn), .aluEn(aluEn), .memEn(memEn), .wbEn(wbEn), .pcEn(pcEn),
        .pcSel(pcSel), .epcSave(epcSave), .intAck(intAck), .halted(halted),
        .retCnt(retCnt), .intVec(intVec)
    );

    cycle_sequencer #(.MEM_WAIT(MEM_WAIT), .RET_CNT_INIT(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .INT(INT), .isHalt(isHalt), .isMem(isMem),
        .isWr(isWr), .memReady(memReady), .stage(w_stage), .irEn(w_irEn),
        .regEn(w_regEn), .aluEn(w_aluEn), .memEn(w_memEn), .wbEn(w_wbEn),
        .pcEn(w_pcEn), .pcSel(w_pcSel), .epcSave(w_epcSave), .intAck(w_intAck),
        .halted(w_halted), .retCnt(w_retCnt), .intVec(w_intVec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {stage, irEn, regEn, aluEn, memEn, wbEn, pcEn, pcSel, epcSave, intAck, halted}
    function automatic logic [12:0] obs_vec();
        return {stage, irEn, regEn, aluEn, memEn, wbEn, pcEn, pcSel, epcSave, intAck, halted};
    endfunction

    // Strobe table: which outputs each stage raises.
    function automatic logic [12:0] exp_vec(input st_t s, input bit wr);
        logic [9:0] f;
        f = '0;
        case (s)
            S_FETCH:  f = 10'b10_0000_0000;
            S_DECODE: f = 10'b01_0000_0000;
            S_EXEC:   f = 10'b00_1000_0000;
            S_MEM:    f = 10'b00_0100_0000;
            S_WB:     f = {4'b0000, wr, 5'b10000};
            S_INTE:   f = 10'b00_0001_1110;
            S_HALT:   f = 10'b00_0000_0001;
            default:  f = '0;
        endcase
        return {3'(s), f};
    endfunction

    // Compare the current cycle, then move to 1ns after the next rising edge.
    task automatic step(input st_t s, input bit wr, input string tag);
        #1;
        check(tag, 32'(obs_vec()), 32'(exp_vec(s, wr)));
        @(posedge clk);
        #1;
    endtask

    // One instruction. lat = number of MEM cycles memReady is held low before
    // rising. int_f = INT level during FETCH/DECODE, int_r = level afterwards.
    task automatic run_instr(input bit is_mem, input bit is_wr, input int lat,
                             input bit int_f, input bit int_r, output int mem_cycles);
        st_t q[$];
        int  n_mem;
        int  k;
        q = {};
        q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        q.push_back(S_EXEC);
        n_mem = is_mem ? ((lat + 1 > MEM_WAIT) ? lat + 1 : MEM_WAIT) : 0;
        for (int j = 0; j < n_mem; j++) q.push_back(S_MEM);
        q.push_back(S_WB);
        if (!int_f) mask_model = 1'b0;
        if (INT_EN && int_r && !mask_model) begin
            q.push_back(S_INTE);
            mask_model = 1'b1;
        end
        mem_cycles = 0;
        k = 0;
        foreach (q[i]) begin
            isHalt = 1'b0;
            isMem  = is_mem;
            isWr   = is_wr;
            INT    = (q[i] == S_FETCH || q[i] == S_DECODE) ? int_f : int_r;
            if (q[i] == S_MEM) begin
                memReady = (k >= lat);
                k++;
            end else begin
                memReady = 1'($urandom_range(0, 1));
            end
            #1;
            if (q[i] == S_FETCH) begin
                check("retcnt", 32'(retCnt), 32'(ret_model));
                check("retcnt_wrap", 32'(w_retCnt), 32'(16'(ret_model + 16'hFFFF)));
            end
            if (memEn) mem_cycles++;
            check("instr_cycle", 32'(obs_vec()), 32'(exp_vec(q[i], is_wr)));
            if (q[i] == S_WB) ret_model = ret_model + 16'd1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("reset_outputs", 32'(obs_vec()), 32'd0);
        check("reset_retcnt", 32'(retCnt), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        ret_model  = 16'd0;
        mask_model = 1'b0;
    endtask

    initial begin
        int mc;
        bit take;
        rst = 1'b0; INT = 1'b0; isHalt = 1'b0; isMem = 1'b0; isWr = 1'b0; memReady = 1'b0;
        ret_model = 16'd0;
        mask_model = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", 32'(obs_vec()), 32'd0);
        check("rst_retcnt", 32'(retCnt), 32'd0);
        check("rst_retcnt_preload", 32'(w_retCnt), 32'h0000_FFFF);
        check("int_vec", intVec, 32'h0000_0040);
        rst = 1'b1;

        // ALU op straight out of reset: FETCH strobe in the first cycle
        run_instr(1'b0, 1'b1, 0, 1'b0, 1'b0, mc);
        #1;
        check("alu_retcnt_1", 32'(retCnt), 32'd1);

        // Loads: fast memory and slow memory
        run_instr(1'b1, 1'b1, 0, 1'b0, 1'b0, mc);
        check("load_fast_memen_cycles", 32'(mc), 32'd3);
        run_instr(1'b1, 1'b0, 5, 1'b0, 1'b0, mc);
        check("load_slow_memen_cycles", 32'(mc), 32'd6);
        run_instr(1'b1, 1'b1, 2, 1'b0, 1'b0, mc);
        check("load_lat2_memen_cycles", 32'(mc), 32'd3);

        // Interrupt raised in EXEC, then held high, then dropped in FETCH
        run_instr(1'b0, 1'b1, 0, 1'b0, 1'b1, mc);
        run_instr(1'b0, 1'b0, 0, 1'b1, 1'b1, mc);
        run_instr(1'b1, 1'b1, 1, 1'b0, 1'b1, mc);
        run_instr(1'b0, 1'b1, 0, 1'b0, 1'b0, mc);

        // Randomized instruction mix
        for (int n = 0; n < 40; n++) begin
            bit m, w, f, r;
            int l;
            m = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 3) == 0);
            l = $urandom_range(0, 6);
            run_instr(m, w, l, f, r, mc);
        end

        // HALT: 20 idle cycles, then an INT pulse
        isHalt = 1'b1; isMem = 1'b0; isWr = 1'b0; INT = 1'b0; memReady = 1'b0;
        mask_model = 1'b0;
        step(S_FETCH, 1'b0, "halt_fetch");
        step(S_DECODE, 1'b0, "halt_decode");
        for (int i = 0; i < 20; i++) step(S_HALT, 1'b0, "halt_hold");
        INT = 1'b1;
        take = INT_EN && !mask_model;
        step(S_HALT, 1'b0, "halt_int");
        INT = 1'b0;
        isHalt = 1'b0;
        step(take ? S_INTE : S_HALT, 1'b0, "halt_exit");
        step(take ? S_FETCH : S_HALT, 1'b0, "halt_after");

        apply_reset();

        // Reset asserted mid-MEM, between clock edges
        isHalt = 1'b0; isMem = 1'b1; isWr = 1'b1; INT = 1'b0; memReady = 1'b0;
        step(S_FETCH, 1'b1, "midmem_fetch");
        step(S_DECODE, 1'b1, "midmem_decode");
        step(S_EXEC, 1'b1, "midmem_exec");
        #1;
        check("midmem_in_mem", 32'(obs_vec()), 32'(exp_vec(S_MEM, 1'b1)));
        #2;
        rst = 1'b0;
        #1;
        check("midmem_async_outputs", 32'(obs_vec()), 32'd0);
        check("midmem_async_retcnt", 32'(retCnt), 32'd0);
        check("midmem_async_preload", 32'(w_retCnt), 32'h0000_FFFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        ret_model = 16'd0;
        mask_model = 1'b0;

        // Preloaded counter wraps to 0 after one instruction
        run_instr(1'b0, 1'b0, 0, 1'b0, 1'b0, mc);
        #1;
        check("wrap_to_zero", 32'(w_retCnt), 32'd0);
        check("retcnt_after_reset", 32'(retCnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cycle_sequencer
